// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master sending 16-bit {rw, addr[6:0], data[7:0]} register frames.
// Define SPI_MASTER_CMD_FIFO_EN to add a 4-entry command FIFO in front of the engine.
module spi_master_ctrl #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_GAP  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       cs_n,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

   localparam int unsigned DW = $clog2(CLK_DIV);
   localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

   state_t        r_state, w_state_nxt;
   logic [DW-1:0] r_div, w_div_nxt;
   logic [3:0]    r_bit, w_bit_nxt;
   logic [GW-1:0] r_gap, w_gap_nxt;
   logic [15:0]   r_shreg, w_shreg_nxt;
   logic [7:0]    r_rx, w_rx_nxt;
   logic          r_rw, w_rw_nxt;
   logic          r_cs_n, w_cs_n_nxt;
   logic          r_sclk, w_sclk_nxt;
   logic          r_mosi, w_mosi_nxt;
   logic          r_rsp_valid, w_rsp_valid_nxt;
   logic [7:0]    r_rdata, w_rdata_nxt;
   logic          w_load;
   logic          w_have;
   logic [15:0]   w_frame;
   logic [15:0]   w_cmd_frame;

   assign w_cmd_frame = {cmd_rw, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata};

`ifdef SPI_MASTER_CMD_FIFO_EN
   localparam bit CHAIN = 1'b1;

   logic [15:0] r_fifo [4];
   logic [1:0]  r_wr_ptr, r_rd_ptr;
   logic [2:0]  r_count;
   logic        w_push, w_pop, w_done;

   // The head entry stays queued until its frame completes, so r_count includes the frame in flight.
   assign w_done    = (r_state == SHIFT) && !r_sclk && (r_div == DIV_LAST) && (r_bit == 4'd15);
   assign w_pop     = w_done;
   assign cmd_ready = !rst && ((r_count != 3'd4) || w_pop);
   assign w_push    = cmd_valid && cmd_ready;
   assign w_have    = (r_count != 3'd0);
   assign w_frame   = r_fifo[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_cmd_frame;
            r_wr_ptr         <= r_wr_ptr + 2'd1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
         r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      end
   end
`else
   localparam bit CHAIN = 1'b0;

   assign cmd_ready = !rst && (r_state == IDLE);
   assign w_have    = cmd_valid;
   assign w_frame   = w_cmd_frame;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_div_nxt       = r_div;
      w_bit_nxt       = r_bit;
      w_gap_nxt       = r_gap;
      w_shreg_nxt     = r_shreg;
      w_rx_nxt        = r_rx;
      w_rw_nxt        = r_rw;
      w_cs_n_nxt      = r_cs_n;
      w_sclk_nxt      = r_sclk;
      w_mosi_nxt      = r_mosi;
      w_rsp_valid_nxt = 1'b0;
      w_rdata_nxt     = r_rdata;
      w_load          = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_have) w_load = 1'b1;
         end
         SETUP: begin
            if (r_div == DIV_LAST) begin
               w_state_nxt = SHIFT;
               w_div_nxt   = '0;
               w_sclk_nxt  = 1'b1;
               w_bit_nxt   = '0;
               w_rx_nxt    = {r_rx[6:0], miso};
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         SHIFT: begin
            if (r_div != DIV_LAST) begin
               w_div_nxt = r_div + 1'b1;
            end else if (r_sclk) begin
               w_div_nxt   = '0;
               w_sclk_nxt  = 1'b0;
               w_shreg_nxt = {r_shreg[14:0], 1'b0};
               w_mosi_nxt  = r_shreg[14];
            end else if (r_bit == 4'd15) begin
               w_state_nxt     = GAP;
               w_div_nxt       = '0;
               w_gap_nxt       = '0;
               w_cs_n_nxt      = 1'b1;
               w_mosi_nxt      = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rdata_nxt     = r_rw ? r_rx : 8'h00;
            end else begin
               w_div_nxt  = '0;
               w_sclk_nxt = 1'b1;
               w_bit_nxt  = r_bit + 4'd1;
               w_rx_nxt   = {r_rx[6:0], miso};
            end
         end
         GAP: begin
            if (r_gap == GAP_LAST) begin
               w_gap_nxt = '0;
               if (CHAIN && w_have) w_load = 1'b1;
               else w_state_nxt = IDLE;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_load) begin
         w_state_nxt = SETUP;
         w_shreg_nxt = w_frame;
         w_rw_nxt    = w_frame[15];
         w_cs_n_nxt  = 1'b0;
         w_mosi_nxt  = w_frame[15];
         w_sclk_nxt  = 1'b0;
         w_div_nxt   = '0;
         w_bit_nxt   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_div       <= '0;
         r_bit       <= '0;
         r_gap       <= '0;
         r_shreg     <= '0;
         r_rx        <= '0;
         r_rw        <= 1'b0;
         r_cs_n      <= 1'b1;
         r_sclk      <= 1'b0;
         r_mosi      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_div       <= w_div_nxt;
         r_bit       <= w_bit_nxt;
         r_gap       <= w_gap_nxt;
         r_shreg     <= w_shreg_nxt;
         r_rx        <= w_rx_nxt;
         r_rw        <= w_rw_nxt;
         r_cs_n      <= w_cs_n_nxt;
         r_sclk      <= w_sclk_nxt;
         r_mosi      <= w_mosi_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rdata     <= w_rdata_nxt;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign busy      = (r_state != IDLE);
   assign cs_n      = r_cs_n;
   assign sclk      = r_sclk;
   assign mosi      = r_mosi;

endmodule
